// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU port and the multi-byte sequencer.
// Opcode constants are common with the ALU itself.
package alu_pkg;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] ADDC = 3'b001;
    localparam logic [2:0] SUB  = 3'b010;
    localparam logic [2:0] SUBB = 3'b011;
    localparam logic [2:0] DEC  = 3'b100;
    localparam logic [2:0] INC  = 3'b101;
    localparam logic [2:0] TRAN = 3'b110;
    localparam logic [2:0] AND  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_mb_seq.sv
// Multi-byte add/sub sequencer driving one 8-bit combinational ALU,
// LSB first, with INC/DEC passes to ripple carry or borrow.
module alu_mb_seq
    import alu_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_sub,
    input  logic [8*NBYTES-1:0]   cmd_a,
    input  logic [8*NBYTES-1:0]   cmd_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_data,
    output logic                  rsp_carry,
    output logic                  rsp_zero,
    output logic [2:0]            alu_opcode,
    output logic [7:0]            alu_opd_1,
    output logic [7:0]            alu_opd_2,
    input  logic [15:0]           alu_res,
    input  logic                  alu_c_flag
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    seq_state_e      state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            sub_q;
    logic [IW-1:0]   idx_q;
    logic            cin_q;
    logic            c1_q;
    logic            zacc_q;
    logic [W-1:0]    data_q;
    logic            carry_q;
    logic            zero_q;
    logic            valid_q;
    logic [2:0]      op_q;
    logic [7:0]      opd1_q;
    logic [7:0]      opd2_q;

    logic [7:0]      res_byte;
    logic            byte_zero;
    logic            commit;
    logic            cout;
    logic            last;
    logic [IW-1:0]   nidx_d;
    logic [7:0]      a_nxt;
    logic [7:0]      b_nxt;
    logic [2:0]      pass_op;
    logic            unused_res_hi;

    // Upper result byte is never needed; a 0x100 result is a zero byte.
    assign unused_res_hi = ^alu_res[15:8];

    always_comb begin
        res_byte  = alu_res[7:0];
        byte_zero = (res_byte == 8'h00);
        commit    = ((state_q == OP) && !cin_q) || (state_q == FIX);
        cout      = (state_q == FIX) ? (c1_q | alu_c_flag) : alu_c_flag;
        last      = (idx_q == IW'(NBYTES - 1));
        nidx_d    = idx_q + 1'b1;
        a_nxt     = a_q[8*nidx_d +: 8];
        b_nxt     = b_q[8*nidx_d +: 8];
        pass_op   = sub_q ? SUBB : ADDC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            cin_q   <= 1'b0;
            c1_q    <= 1'b0;
            zacc_q  <= 1'b0;
            data_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            op_q    <= ADD;
            opd1_q  <= 8'h00;
            opd2_q  <= 8'h00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        a_q     <= cmd_a;
                        b_q     <= cmd_b;
                        sub_q   <= cmd_sub;
                        idx_q   <= '0;
                        cin_q   <= 1'b0;
                        c1_q    <= 1'b0;
                        zacc_q  <= 1'b1;
                        op_q    <= cmd_sub ? SUBB : ADDC;
                        opd1_q  <= cmd_a[7:0];
                        opd2_q  <= cmd_b[7:0];
                        state_q <= OP;
                    end
                end
                OP: begin
                    c1_q <= alu_c_flag;
                    if (cin_q) begin
                        op_q    <= sub_q ? DEC : INC;
                        opd1_q  <= res_byte;
                        opd2_q  <= 8'h00;
                        state_q <= FIX;
                    end
                end
                FIX: begin
                end
                DONE: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Byte commit is shared by a carry-free OP pass and a FIX pass.
            if (commit) begin
                data_q[8*idx_q +: 8] <= res_byte;
                zacc_q <= zacc_q & byte_zero;
                cin_q  <= cout;
                if (last) begin
                    valid_q <= 1'b1;
                    carry_q <= cout;
                    zero_q  <= zacc_q & byte_zero;
                    op_q    <= ADD;
                    opd1_q  <= 8'h00;
                    opd2_q  <= 8'h00;
                    state_q <= DONE;
                end else begin
                    idx_q   <= nidx_d;
                    op_q    <= pass_op;
                    opd1_q  <= a_nxt;
                    opd2_q  <= b_nxt;
                    state_q <= OP;
                end
            end
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = valid_q;
    assign rsp_data   = data_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;
    assign alu_opcode = op_q;
    assign alu_opd_1  = opd1_q;
    assign alu_opd_2  = opd2_q;

endmodule

// File: tb/tb_alu_mb_seq.sv
// Scoreboard bench for alu_mb_seq with a behavioural 8-bit ALU beside it.
// Checks result, flags, latency and the exact ALU pass sequence.
module tb_alu_mb_seq;
    import alu_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        logic         z;
        int           n;
        logic [23:0]  ops;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_sub;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_carry;
    logic          rsp_zero;
    logic [2:0]    alu_opcode;
    logic [7:0]    alu_opd_1;
    logic [7:0]    alu_opd_2;
    logic [15:0]   alu_res;
    logic          alu_c_flag;

    int   n_chk;
    int   n_fail;
    int   cyc;
    int   acc_cyc;
    int   first_cyc;
    bit   seen;
    exp_t sb[$];
    logic [2:0] opq[$];

    alu_mb_seq #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sub    (cmd_sub),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .alu_opcode (alu_opcode),
        .alu_opd_1  (alu_opd_1),
        .alu_opd_2  (alu_opd_2),
        .alu_res    (alu_res),
        .alu_c_flag (alu_c_flag)
    );

    // Reference ALU: flag is carry-out for add/inc, borrow for sub/dec.
    always_comb begin
        alu_res    = 16'h0000;
        alu_c_flag = 1'b0;
        case (alu_opcode)
            ADD, ADDC: begin
                alu_res    = {8'h00, alu_opd_1} + {8'h00, alu_opd_2};
                alu_c_flag = alu_res[8];
            end
            SUB, SUBB: begin
                alu_res    = {8'h00, alu_opd_1} - {8'h00, alu_opd_2};
                alu_c_flag = (alu_opd_1 < alu_opd_2);
            end
            INC: begin
                alu_res    = {8'h00, alu_opd_1} + 16'h0001;
                alu_c_flag = (alu_opd_1 == 8'hFF);
            end
            DEC: begin
                alu_res    = {8'h00, alu_opd_1} - 16'h0001;
                alu_c_flag = (alu_opd_1 == 8'h00);
            end
            default: begin
                alu_res    = 16'h0000;
                alu_c_flag = 1'b0;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input logic c,
                                input logic z, input int n,
                                input logic [23:0] ops);
        exp_t e;
        e.d = d;
        e.c = c;
        e.z = z;
        e.n = n;
        e.ops = ops;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && alu_opcode != ADD) opq.push_back(alu_opcode);
    end

    // Monitor: compares each completed response against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (rsp_valid && !seen) begin
                seen = 1'b1;
                first_cyc = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    logic [23:0] g;
                    e = sb.pop_front();
                    g = '0;
                    foreach (opq[i]) g = {g[20:0], opq[i]};
                    chk("rsp_data", 64'(rsp_data), 64'(e.d));
                    chk("rsp_carry", 64'(rsp_carry), 64'(e.c));
                    chk("rsp_zero", 64'(rsp_zero), 64'(e.z));
                    chk("latency", 64'(first_cyc - acc_cyc), 64'(e.n));
                    chk("pass_count", 64'(opq.size()), 64'(e.n));
                    chk("pass_seq", 64'(g), 64'(e.ops));
                end
                seen = 1'b0;
            end
        end
    end

    task automatic bookkeep(input exp_t e, input bit push);
        acc_cyc = cyc;
        opq.delete();
        if (push) sb.push_back(e);
        cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input exp_t e, input bit push);
        bit ok;
        @(posedge clk);
        #1;
        cmd_a = a;
        cmd_b = b;
        cmd_sub = sub;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 64'd1, 64'd0);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bookkeep(e, push);
        end
    endtask

    initial begin
        bit ok;
        n_chk = 0;
        n_fail = 0;
        seen = 1'b0;
        acc_cyc = 0;
        first_cyc = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_sub = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        rsp_ready = 1'b1;

        #12;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu_opcode", 64'(alu_opcode), 64'(ADD));
        chk("rst_alu_opds", 64'({alu_opd_1, alu_opd_2}), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_flags", 64'({rsp_carry, rsp_zero}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(32'h000000FF, 32'h00000001, 1'b0,
             mk(32'h00000100, 1'b0, 1'b0, 5,
                {ADDC, ADDC, INC, ADDC, ADDC}), 1'b1);
        send(32'hFFFFFFFF, 32'h00000001, 1'b0,
             mk(32'h00000000, 1'b1, 1'b1, 7,
                {ADDC, ADDC, INC, ADDC, INC, ADDC, INC}), 1'b1);
        send(32'h00000000, 32'h00000001, 1'b1,
             mk(32'hFFFFFFFF, 1'b1, 1'b0, 7,
                {SUBB, SUBB, DEC, SUBB, DEC, SUBB, DEC}), 1'b1);
        send(32'h12345678, 32'h12345678, 1'b1,
             mk(32'h00000000, 1'b0, 1'b1, 4,
                {SUBB, SUBB, SUBB, SUBB}), 1'b1);

        // Back-pressure in DONE with the next command already waiting.
        send(32'h12345678, 32'h11111111, 1'b0,
             mk(32'h23456789, 1'b0, 1'b0, 4,
                {ADDC, ADDC, ADDC, ADDC}), 1'b1);
        rsp_ready = 1'b0;
        cmd_a = 32'h00000100;
        cmd_b = 32'h00000001;
        cmd_sub = 1'b1;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("stall_rsp_seen", 64'(ok), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_data", 64'(rsp_data), 64'h23456789);
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        bookkeep(mk(32'h000000FF, 1'b0, 1'b0, 5,
                    {SUBB, SUBB, DEC, SUBB, SUBB}), 1'b1);
        chk("next_cmd_accepted", 64'(cmd_ready), 64'd0);

        // Asynchronous reset in the middle of a FIX pass.
        send(32'hFFFFFFFF, 32'h00000001, 1'b0,
             mk('0, 1'b0, 1'b0, 0, '0), 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (alu_opcode == INC) begin
                ok = 1'b1;
                break;
            end
        end
        chk("fix_pass_seen", 64'(ok), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst_alu_opcode", 64'(alu_opcode), 64'(ADD));
        chk("arst_alu_opd_1", 64'(alu_opd_1), 64'd0);
        chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h80000000, 32'h80000000, 1'b0,
             mk(32'h00000000, 1'b1, 1'b1, 4,
                {ADDC, ADDC, ADDC, ADDC}), 1'b1);

        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_scoreboard", 64'(ok), 64'd1);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
